// File: rtl/if_align_buffer_if.sv
// ----------------------------------------------------------------------------
// if_align_buffer_if
// Purpose : groups the icache request/response bus and the fetch-stage
//           instruction handshake of the instruction realignment buffer.
// Signals : icache_req_o / icache_addr_o / icache_kill_o  (buffer -> icache)
//           icache_ack_i / icache_rdata_i                 (icache -> buffer)
//           instr_valid_o / instr_o / is_cmp_o / pc_o     (buffer -> fetch)
//           instr_ready_i                                 (fetch  -> buffer)
// Modports: master = the align buffer, slave = its environment.
// ----------------------------------------------------------------------------
interface if_align_buffer_if #(
    parameter int XLEN = 32
);
    logic            icache_req_o;
    logic [XLEN-1:0] icache_addr_o;
    logic            icache_kill_o;
    logic            icache_ack_i;
    logic [31:0]     icache_rdata_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instr_o;
    logic            is_cmp_o;
    logic [XLEN-1:0] pc_o;

    modport master (
        output icache_req_o, icache_addr_o, icache_kill_o,
        output instr_valid_o, instr_o, is_cmp_o, pc_o,
        input  icache_ack_i, icache_rdata_i, instr_ready_i
    );

    modport slave (
        input  icache_req_o, icache_addr_o, icache_kill_o,
        input  instr_valid_o, instr_o, is_cmp_o, pc_o,
        output icache_ack_i, icache_rdata_i, instr_ready_i
    );
endinterface

// File: rtl/if_align_buffer.sv
// ----------------------------------------------------------------------------
// if_align_buffer
// Purpose : instruction realignment buffer between icache and fetch stage.
//           Issues word-aligned fetches, stores returned words as halfwords
//           in a circular queue and hands out one complete instruction
//           (16-bit compressed or 32-bit, possibly word-straddling) per
//           handshake together with its PC. A redirect kills the in-flight
//           request, empties the queue and refetches from the new PC.
// Ports   : clk        - clock, rising edge
//           rst_n      - asynchronous active-low reset
//           flush_i    - redirect request
//           flush_pc_i - redirect target
//           bus_io     - if_align_buffer_if.master (icache + fetch handshake)
// Config  : IF_ALIGN_RVC_EN defined  -> compressed instructions and
//           halfword-aligned redirect targets are supported.
//           IF_ALIGN_RVC_EN undefined -> every instruction is two halfwords,
//           targets are fetched from the aligned word.
// ----------------------------------------------------------------------------
module if_align_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH_HW = 6,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [XLEN-1:0]     flush_pc_i,
    if_align_buffer_if.master   bus_io
);
    localparam int PTR_W = $clog2(DEPTH_HW);
    localparam int CNT_W = $clog2(DEPTH_HW + 1);
    localparam logic [CNT_W-1:0] REFILL_LVL = CNT_W'(DEPTH_HW - 2);

`ifdef IF_ALIGN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t           state_q;
    logic [XLEN-1:0]  fetch_addr_q;
    logic [XLEN-1:0]  pc_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             drop_lo_q;
    logic [15:0]      q_mem [DEPTH_HW];

    // Pointers wrap at DEPTH_HW, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_HW - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0] rd_ptr_p1, rd_ptr_p2, wr_ptr_p1, wr_ptr_p2;
    logic [15:0]      hw0, hw1;
    logic             has1, has2, is_cmp, valid, pop, ack_ok;
    logic [CNT_W-1:0] push_n, pop_n, count_d;

    assign rd_ptr_p1 = ptr_inc(rd_ptr_q);
    assign rd_ptr_p2 = ptr_inc(rd_ptr_p1);
    assign wr_ptr_p1 = ptr_inc(wr_ptr_q);
    assign wr_ptr_p2 = ptr_inc(wr_ptr_p1);

    assign hw0  = q_mem[rd_ptr_q];
    assign hw1  = q_mem[rd_ptr_p1];
    assign has1 = (count_q != '0);
    assign has2 = (count_q >= CNT_W'(2));

    // Head decode uses registered queue state only; gating with has1 keeps
    // stale entries from ever looking like a compressed instruction.
    assign is_cmp = RVC & has1 & (hw0[1:0] != 2'b11);
    assign valid  = (is_cmp & has1) | (~is_cmp & has2);

    assign pop     = valid & bus_io.instr_ready_i & ~flush_i;
    assign ack_ok  = (state_q == S_WAIT) & bus_io.icache_ack_i & ~flush_i;
    assign push_n  = ack_ok ? (drop_lo_q ? CNT_W'(1) : CNT_W'(2)) : '0;
    assign pop_n   = pop ? (is_cmp ? CNT_W'(1) : CNT_W'(2)) : '0;
    // A request is only launched with room for a full word, so this never
    // exceeds DEPTH_HW.
    assign count_d = count_q + push_n - pop_n;

    assign bus_io.icache_req_o  = (state_q == S_WAIT);
    assign bus_io.icache_addr_o = fetch_addr_q;
    assign bus_io.icache_kill_o = flush_i & (state_q == S_WAIT);
    assign bus_io.instr_valid_o = valid;
    assign bus_io.is_cmp_o      = is_cmp;
    assign bus_io.pc_o          = pc_q;
    assign bus_io.instr_o       = !valid ? 32'h0 :
                                  (is_cmp ? {16'h0, hw0} : {hw1, hw0});

    // Queue storage: plain array, no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (ack_ok) begin
            if (drop_lo_q) begin
                q_mem[wr_ptr_q] <= bus_io.icache_rdata_i[31:16];
            end else begin
                q_mem[wr_ptr_q]  <= bus_io.icache_rdata_i[15:0];
                q_mem[wr_ptr_p1] <= bus_io.icache_rdata_i[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= {RESET_PC[XLEN-1:2], 2'b00};
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            drop_lo_q    <= RVC & RESET_PC[1];
        end else if (flush_i) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            pc_q         <= flush_pc_i;
            fetch_addr_q <= {flush_pc_i[XLEN-1:2], 2'b00};
            drop_lo_q    <= RVC & flush_pc_i[1];
            // The queue is empty after a redirect, so the idle step would
            // always launch; go straight to the request to save a cycle.
            state_q      <= S_WAIT;
        end else begin
            count_q <= count_d;
            if (ack_ok) begin
                wr_ptr_q <= drop_lo_q ? wr_ptr_p1 : wr_ptr_p2;
            end
            if (pop) begin
                rd_ptr_q <= is_cmp ? rd_ptr_p1 : rd_ptr_p2;
                pc_q     <= pc_q + (is_cmp ? XLEN'(2) : XLEN'(4));
            end
            case (state_q)
                S_IDLE: begin
                    if (count_q <= REFILL_LVL) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack_ok) begin
                        fetch_addr_q <= fetch_addr_q + XLEN'(4);
                        drop_lo_q    <= 1'b0;
                        state_q      <= (count_d <= REFILL_LVL) ? S_WAIT : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_align_buffer.sv
module tb_if_align_buffer;
    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ack_en;
    logic        ready;
    logic [31:0] imem [256];

    int total = 0;
    int bad   = 0;

    if_align_buffer_if #(.XLEN(32)) bus ();

    if_align_buffer #(
        .XLEN     (32),
        .DEPTH_HW (6),
        .RESET_PC (32'h8000_0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .flush_pc_i (flush_pc),
        .bus_io     (bus.master)
    );

    // Zero-wait icache: acknowledges in the same cycle the request is seen.
    assign bus.icache_ack_i   = ack_en & bus.icache_req_o;
    assign bus.icache_rdata_i = imem[bus.icache_addr_o[9:2]];
    assign bus.instr_ready_i  = ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    typedef struct {
        int          delay;   // cycles with ready low before accepting
        logic [31:0] instr;
        logic [31:0] pc;
        logic        cmp;
    } vec_t;

    vec_t vecs [6];
    logic [31:0] exp_fl_instr;
    logic        exp_fl_cmp;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'h0000_0013;
        imem[1]  = 32'h4501_4505;
        imem[2]  = 32'h0093_4505;
        imem[3]  = 32'h0013_0000;
        imem[4]  = 32'h0000_0000;
        imem[64] = 32'h4505_0000;   // redirect target word at 0x8000_0100

`ifdef IF_ALIGN_RVC_EN
        vecs[0] = '{0,  32'h0000_0013, 32'h8000_0000, 1'b0};
        vecs[1] = '{0,  32'h0000_4505, 32'h8000_0004, 1'b1};
        vecs[2] = '{20, 32'h0000_4501, 32'h8000_0006, 1'b1};
        vecs[3] = '{0,  32'h0000_4505, 32'h8000_0008, 1'b1};
        vecs[4] = '{0,  32'h0000_0093, 32'h8000_000A, 1'b0};  // straddles words 2/3
        vecs[5] = '{0,  32'h0000_0013, 32'h8000_000E, 1'b0};  // straddles words 3/4
        exp_fl_instr = 32'h0000_4505;
        exp_fl_cmp   = 1'b1;
`else
        vecs[0] = '{0,  32'h0000_0013, 32'h8000_0000, 1'b0};
        vecs[1] = '{0,  32'h4501_4505, 32'h8000_0004, 1'b0};
        vecs[2] = '{20, 32'h0093_4505, 32'h8000_0008, 1'b0};
        vecs[3] = '{0,  32'h0013_0000, 32'h8000_000C, 1'b0};
        vecs[4] = '{0,  32'h0000_0000, 32'h8000_0010, 1'b0};
        vecs[5] = '{0,  32'h0000_0013, 32'h8000_0014, 1'b0};
        exp_fl_instr = 32'h4505_0000;
        exp_fl_cmp   = 1'b0;
`endif

        rst_n    = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;
        ack_en   = 1'b0;
        ready    = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check("rst_req",   32'(bus.icache_req_o),  32'h0);
        check("rst_kill",  32'(bus.icache_kill_o), 32'h0);
        check("rst_addr",  bus.icache_addr_o,      32'h8000_0000);
        check("rst_valid", 32'(bus.instr_valid_o), 32'h0);
        check("rst_instr", bus.instr_o,            32'h0);
        check("rst_cmp",   32'(bus.is_cmp_o),      32'h0);
        check("rst_pc",    bus.pc_o,               32'h8000_0000);

        rst_n  = 1'b1;
        ack_en = 1'b1;

        // ---- first request and ack-to-valid latency ----
        @(negedge clk);
        check("first_req",  32'(bus.icache_req_o), 32'h1);
        check("first_addr", bus.icache_addr_o,     32'h8000_0000);
        @(negedge clk);
        check("first_valid", 32'(bus.instr_valid_o), 32'h1);
        check("first_instr", bus.instr_o,            32'h0000_0013);
        check("first_cmp",   32'(bus.is_cmp_o),      32'h0);
        check("first_pc",    bus.pc_o,               32'h8000_0000);

        // ---- table-driven instruction stream ----
        for (int i = 0; i < 6; i++) begin
            int n;
            ready = 1'b0;
            repeat (vecs[i].delay) @(negedge clk);
            if (vecs[i].delay >= 20) begin
                check($sformatf("v%0d_stall_req", i), 32'(bus.icache_req_o), 32'h0);
            end
            ready = 1'b1;
            n = 0;
            while (!bus.instr_valid_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d_valid", i), 32'(bus.instr_valid_o), 32'h1);
            check($sformatf("v%0d_instr", i), bus.instr_o,            vecs[i].instr);
            check($sformatf("v%0d_pc", i),    bus.pc_o,               vecs[i].pc);
            check($sformatf("v%0d_cmp", i),   32'(bus.is_cmp_o),      32'(vecs[i].cmp));
            @(negedge clk);
        end

        // ---- redirect to a halfword target while a request is pending ----
        begin
            int n;
            ack_en = 1'b0;
            ready  = 1'b1;
            repeat (2) @(negedge clk);
            ready = 1'b0;
            n = 0;
            while (!bus.icache_req_o && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("fl_pending_req", 32'(bus.icache_req_o), 32'h1);
        end
        flush    = 1'b1;
        flush_pc = 32'h8000_0102;
        ack_en   = 1'b1;   // same-cycle ack must be discarded
        ready    = 1'b1;   // same-cycle pop must be ignored
        #1;
        check("fl_kill", 32'(bus.icache_kill_o), 32'h1);
        @(negedge clk);
        flush = 1'b0;
        ready = 1'b0;
        #1;
        check("fl_kill_clr", 32'(bus.icache_kill_o), 32'h0);
        check("fl_req",      32'(bus.icache_req_o),  32'h1);
        check("fl_addr",     bus.icache_addr_o,      32'h8000_0100);
        check("fl_empty",    32'(bus.instr_valid_o), 32'h0);
        check("fl_pc",       bus.pc_o,               32'h8000_0102);
        @(negedge clk);
        check("fl_out_valid", 32'(bus.instr_valid_o), 32'h1);
        check("fl_out_instr", bus.instr_o,            exp_fl_instr);
        check("fl_out_cmp",   32'(bus.is_cmp_o),      32'(exp_fl_cmp));
        check("fl_out_pc",    bus.pc_o,               32'h8000_0102);

        // ---- reset in the middle of a pending request ----
        ack_en = 1'b0;
        ready  = 1'b1;
        repeat (3) @(negedge clk);
        check("mr_pending_req", 32'(bus.icache_req_o), 32'h1);
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        check("mr_req",   32'(bus.icache_req_o),  32'h0);
        check("mr_kill",  32'(bus.icache_kill_o), 32'h0);
        check("mr_pc",    bus.pc_o,               32'h8000_0000);
        check("mr_valid", 32'(bus.instr_valid_o), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_re_req",  32'(bus.icache_req_o), 32'h1);
        check("mr_re_addr", bus.icache_addr_o,     32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
